// File: rtl/fp16_subtractor.sv
// Multi-cycle IEEE-754 binary16 subtractor (x = a - b): subnormals flush to zero and results truncate.
// Valid/ready handshake on both sides; normalisation costs one cycle per left shift.
module fp16_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_SUB,
    S_NORM,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [21:0] sig_big_q, sig_big_d;
  logic [21:0] sig_small_q, sig_small_d;
  logic [21:0] sig_q, sig_d;
  logic [5:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        eff_sub_q, eff_sub_d;
  logic        zero_q, zero_d;
  logic        inf_q, inf_d;
  logic [15:0] x_q, x_d;

  // Alignment datapath: operates on the captured operands.
  logic [4:0]  a_exp, b_exp;
  logic [9:0]  a_man, b_man;
  logic [21:0] a_sig, b_sig;
  logic        nb_sign;
  logic        a_ge_b;
  logic [4:0]  exp_diff;
  logic [21:0] big_sig, small_sig, small_shifted;
  logic [4:0]  big_exp;
  logic        big_sign;

  assign a_exp   = a_q[14:10];
  assign b_exp   = b_q[14:10];
  assign a_man   = a_q[9:0];
  assign b_man   = b_q[9:0];
  assign nb_sign = ~b_q[15];

  // An exponent field of zero means the operand contributes nothing.
  assign a_sig = (a_exp == 5'd0) ? 22'd0 : {1'b0, 1'b1, a_man, 10'd0};
  assign b_sig = (b_exp == 5'd0) ? 22'd0 : {1'b0, 1'b1, b_man, 10'd0};

  assign a_ge_b    = (a_q[14:0] >= b_q[14:0]);
  assign big_sig   = a_ge_b ? a_sig : b_sig;
  assign small_sig = a_ge_b ? b_sig : a_sig;
  assign big_exp   = a_ge_b ? a_exp : b_exp;
  assign big_sign  = a_ge_b ? a_q[15] : nb_sign;
  assign exp_diff  = a_ge_b ? (a_exp - b_exp) : (b_exp - a_exp);

  assign small_shifted = (exp_diff >= 5'd22) ? 22'd0 : (small_sig >> exp_diff);

  // Significand combine and normalisation helpers.
  logic [21:0] sum;
  logic [5:0]  exp_inc;
  logic        need_shift;

  assign sum     = eff_sub_q ? (sig_big_q - sig_small_q) : (sig_big_q + sig_small_q);
  assign exp_inc = exp_q + 6'd1;

  assign need_shift = !zero_q && !inf_q && !sig_q[20] && (sig_q != 22'd0) && (exp_q > 6'd1);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sig_big_d   = sig_big_q;
    sig_small_d = sig_small_q;
    sig_d       = sig_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    zero_d      = zero_q;
    inf_d       = inf_q;
    x_d         = x_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = S_ALIGN;
        end
      end

      S_ALIGN: begin
        sig_big_d   = big_sig;
        sig_small_d = small_shifted;
        exp_d       = {1'b0, big_exp};
        sign_d      = big_sign;
        eff_sub_d   = a_q[15] ^ nb_sign;
        state_d     = S_SUB;
      end

      S_SUB: begin
        zero_d = 1'b0;
        inf_d  = 1'b0;
        if (sum == 22'd0) begin
          zero_d = 1'b1;
          sig_d  = 22'd0;
        end else if (sum[21]) begin
          sig_d = sum >> 1;
          exp_d = exp_inc;
          inf_d = (exp_inc >= 6'd31);
        end else begin
          sig_d = sum;
        end
        state_d = S_NORM;
      end

      S_NORM: begin
        if (need_shift) begin
          sig_d = sig_q << 1;
          exp_d = exp_q - 6'd1;
        end else begin
          if (zero_q) begin
            x_d = 16'h0000;
          end else if (inf_q) begin
            x_d = {sign_q, 5'h1F, 10'h000};
          end else if (!sig_q[20]) begin
            // Ran out of exponent range before reaching the hidden bit.
            x_d = {sign_q, 15'h0000};
          end else begin
            x_d = {sign_q, exp_q[4:0], sig_q[19:10]};
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      sig_big_q   <= 22'd0;
      sig_small_q <= 22'd0;
      sig_q       <= 22'd0;
      exp_q       <= 6'd0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      zero_q      <= 1'b0;
      inf_q       <= 1'b0;
      x_q         <= 16'h0000;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sig_big_q   <= sig_big_d;
      sig_small_q <= sig_small_d;
      sig_q       <= sig_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      eff_sub_q   <= eff_sub_d;
      zero_q      <= zero_d;
      inf_q       <= inf_d;
      x_q         <= x_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign x         = x_q;

endmodule
